// File: rtl/alu_mul_sequencer_if.sv
// Bundle between microcode/issue logic and the multiply sequencer,
// plus the shared ALU control/operand/result buses.
interface alu_mul_sequencer_if;
  // multiply request / response
  logic        start;
  logic        op_signed;
  logic [31:0] mcand;
  logic [31:0] mpr;
  logic        busy;
  logic        done;
  logic [63:0] prod;
  // microcode ALU request
  logic        uc_req;
  logic        uc_stall;
  logic [3:0]  uc_aluf;
  logic        uc_alumode;
  logic        uc_cin0;
  logic [31:0] uc_m;
  logic [31:0] uc_a;
  // ALU side
  logic [3:0]  alu_aluf;
  logic        alu_alumode;
  logic        alu_cin0;
  logic [31:0] alu_m;
  logic [31:0] alu_a;
  logic [32:0] alu;

  modport master (
    output start, op_signed, mcand, mpr,
    output uc_req, uc_aluf, uc_alumode,
    output uc_cin0, uc_m, uc_a,
    output alu,
    input  busy, done, prod, uc_stall,
    input  alu_aluf, alu_alumode, alu_cin0,
    input  alu_m, alu_a
  );

  modport slave (
    input  start, op_signed, mcand, mpr,
    input  uc_req, uc_aluf, uc_alumode,
    input  uc_cin0, uc_m, uc_a,
    input  alu,
    output busy, done, prod, uc_stall,
    output alu_aluf, alu_alumode, alu_cin0,
    output alu_m, alu_a
  );
endinterface

// File: rtl/alu_mul_sequencer.sv
// Shift-and-add multiply sequencer sharing the 32-bit '181 ALU with microcode.
// Ports: clk, reset (sync, active-high), bus (alu_mul_sequencer_if.slave).
// Optional: define ALU_MUL_SIGNED_EN to honour op_signed (signed x signed).
module alu_mul_sequencer #(
  parameter int N_STEPS = 32,
  parameter int CNT_W   = 6
) (
  input logic               clk,
  input logic               reset,
  alu_mul_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_STEP,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(N_STEPS - 1);

  state_t           r_state;
  state_t           w_next;
  logic [31:0]      r_acc;
  logic [31:0]      r_q;
  logic [31:0]      r_mc;
  logic [CNT_W-1:0] r_cnt;
  logic [63:0]      r_prod;

  logic             w_last;
  logic             w_sub;
  logic             w_carry;
  logic             w_t;
  logic [63:0]      w_shift;

`ifdef ALU_MUL_SIGNED_EN
  logic             r_sgn;
  // final step of a signed op weights the
  // multiplier sign bit negatively
  assign w_sub = r_sgn & w_last & r_q[0];
  assign w_t   = r_sgn ? bus.alu[32] : w_carry;
`else
  assign w_sub = 1'b0;
  assign w_t   = w_carry;
`endif

  assign w_last = (r_cnt == LAST);

  // recover the true carry out of bit 31;
  // a pass step can never carry
  assign w_carry = r_q[0] &
    (bus.alu[32] ^ r_acc[31] ^ r_mc[31]);

  assign w_shift = {w_t, bus.alu[31:0], r_q[31:1]};

  assign bus.busy     = (r_state != S_IDLE);
  assign bus.done     = (r_state == S_DONE);
  assign bus.uc_stall = bus.uc_req & bus.busy;
  assign bus.prod     = r_prod;

  always_comb begin
    w_next          = r_state;
    bus.alu_aluf    = 4'b1111;
    bus.alu_alumode = 1'b1;
    bus.alu_cin0    = 1'b0;
    bus.alu_m       = r_acc;
    bus.alu_a       = r_mc;
    unique case (r_state)
      S_IDLE: begin
        bus.alu_aluf    = bus.uc_aluf;
        bus.alu_alumode = bus.uc_alumode;
        bus.alu_cin0    = bus.uc_cin0;
        bus.alu_m       = bus.uc_m;
        bus.alu_a       = bus.uc_a;
        if (bus.start)
          w_next = S_LOAD;
      end
      S_LOAD: w_next = S_STEP;
      S_STEP: begin
        if (w_sub) begin
          bus.alu_aluf    = 4'b0110;
          bus.alu_alumode = 1'b0;
          bus.alu_cin0    = 1'b1;
        end else if (r_q[0]) begin
          bus.alu_aluf    = 4'b1001;
          bus.alu_alumode = 1'b0;
        end
        if (w_last)
          w_next = S_DONE;
      end
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_q     <= '0;
      r_mc    <= '0;
      r_cnt   <= '0;
      r_prod  <= '0;
`ifdef ALU_MUL_SIGNED_EN
      r_sgn   <= 1'b0;
`endif
    end else begin
      r_state <= w_next;
      // operands latched at the accept edge
      if (r_state == S_IDLE && bus.start) begin
        r_acc <= '0;
        r_q   <= bus.mpr;
        r_mc  <= bus.mcand;
        r_cnt <= '0;
`ifdef ALU_MUL_SIGNED_EN
        r_sgn <= bus.op_signed;
`endif
      end
      if (r_state == S_STEP) begin
        {r_acc, r_q} <= w_shift;
        r_cnt        <= r_cnt + CNT_W'(1);
        // product visible during the done cycle
        if (w_last)
          r_prod <= w_shift;
      end
      if (r_state == S_DONE)
        r_prod <= {r_acc, r_q};
    end
  end

endmodule
